// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: table-driven decision-tree classifier.
// Loads a node table at runtime, then walks one node per clock
// from the root (address 0) until it reaches a leaf or the depth limit.
// Results go out over a valid/ready handshake.
module dtree_seq_eval #(
  parameter int N_FEAT    = 16,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 4,
  parameter int NODE_AW   = 6,
  parameter int MAX_DEPTH = 16,
  parameter int FIDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
  parameter int NODE_W    = 1 + FIDX_W + FEAT_W + 2*NODE_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
);

  localparam int TABLE_DEPTH = 2**NODE_AW;
  localparam int DEPTH_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [NODE_W-1:0] RESET_NODE = {1'b1, {(NODE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  state_t                     state_q;
  logic [NODE_W-1:0]          table_q [TABLE_DEPTH];
  logic [N_FEAT*FEAT_W-1:0]   feat_q;
  logic [NODE_AW-1:0]         ptr_q;
  logic [DEPTH_W-1:0]         depth_q;
  logic                       outValid_q;
  logic [CLASS_W-1:0]         outClass_q;
  logic                       outErr_q;
  logic                       inReady_q;
  logic                       cfgBusy_q;

  logic [NODE_W-1:0]          node_d;
  logic                       isLeaf_d;
  logic [FIDX_W-1:0]          featIdx_d;
  logic [FEAT_W-1:0]          thresh_d;
  logic [NODE_AW-1:0]         left_d;
  logic [NODE_AW-1:0]         right_d;
  logic [CLASS_W-1:0]         leafClass_d;
  logic [FEAT_W-1:0]          featVal_d;
  logic [NODE_AW-1:0]         nextPtr_d;

  // Split the current node word into its fields.
  always_comb begin
    node_d      = table_q[ptr_q];
    isLeaf_d    = node_d[NODE_W-1];
    featIdx_d   = node_d[2*NODE_AW+FEAT_W +: FIDX_W];
    thresh_d    = node_d[2*NODE_AW +: FEAT_W];
    left_d      = node_d[NODE_AW +: NODE_AW];
    right_d     = node_d[0 +: NODE_AW];
    leafClass_d = node_d[CLASS_W-1:0];
  end

  // Select the addressed feature; indices beyond N_FEAT read as zero.
  always_comb begin
    featVal_d = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (featIdx_d == FIDX_W'(i)) begin
        featVal_d = feat_q[i*FEAT_W +: FEAT_W];
      end
    end
  end

  // Branch decision: less-or-equal goes left, otherwise right.
  always_comb begin
    nextPtr_d = (featVal_d <= thresh_d) ? left_d : right_d;
  end

  // Node table: every entry resets to "leaf, class 0"; writes only land in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        table_q[i] <= RESET_NODE;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  // Controller: accept a vector, walk one node per cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      ptr_q      <= '0;
      depth_q    <= '0;
      outValid_q <= 1'b0;
      outClass_q <= '0;
      outErr_q   <= 1'b0;
      inReady_q  <= 1'b1;
      cfgBusy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            feat_q    <= in_feat;
            ptr_q     <= '0;
            depth_q   <= '0;
            inReady_q <= 1'b0;
            cfgBusy_q <= 1'b1;
            state_q   <= WALK;
          end
        end
        WALK: begin
          if (isLeaf_d) begin
            outClass_q <= leafClass_d;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (depth_q == DEPTH_W'(MAX_DEPTH-1)) begin
            outClass_q <= '0;
            outErr_q   <= 1'b1;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            ptr_q   <= nextPtr_d;
            depth_q <= depth_q + DEPTH_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            cfgBusy_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_busy  = cfgBusy_q;
  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_class = outClass_q;
  assign out_err   = outErr_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: directed scenarios for the decision-tree walker
// with hand-computed classes and latencies.
module tb_dtree_seq_eval;

  localparam int N_FEAT  = 16;
  localparam int FEAT_W  = 8;
  localparam int CLASS_W = 4;
  localparam int NODE_AW = 6;
  localparam int NODE_W  = 25;
  localparam int FV_W    = N_FEAT*FEAT_W;

  logic               clk;
  logic               rst_n;
  logic               cfg_we;
  logic [NODE_AW-1:0] cfg_addr;
  logic [NODE_W-1:0]  cfg_data;
  logic               cfg_busy;
  logic               in_valid;
  logic               in_ready;
  logic [FV_W-1:0]    in_feat;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic               out_err;

  int checks = 0;
  int passes = 0;

  dtree_seq_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Last-resort guard so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [NODE_W-1:0] mkLeaf(input logic [3:0] c);
    return {1'b1, 20'b0, c};
  endfunction

  function automatic logic [NODE_W-1:0] mkInt(input logic [3:0] fi, input logic [7:0] thr,
                                               input logic [5:0] l, input logic [5:0] r);
    return {1'b0, fi, thr, l, r};
  endfunction

  function automatic logic [FV_W-1:0] featWith(input int idx, input logic [7:0] val,
                                               input logic [7:0] others);
    logic [FV_W-1:0] f;
    f = {N_FEAT{others}};
    f[idx*FEAT_W +: FEAT_W] = val;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeNode(input logic [5:0] addr, input logic [NODE_W-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Present a vector until it is taken; afterwards scramble in_feat so only the latched copy matters.
  task automatic sendVector(input logic [FV_W-1:0] f);
    int n;
    n = 0;
    in_feat  = f;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_feat  = ~f;
  endtask

  // Count cycles after acceptance until out_valid; -1 on timeout.
  task automatic waitResult(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    lat = out_valid ? n : -1;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (cfg_busy !== 1'b0) $display("[TB] FAIL reset_cfg_busy: got %b expected 0", cfg_busy); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_class !== 4'd0) $display("[TB] FAIL reset_out_class: got %0d expected 0", out_class); else passes++;
    checks++; if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); else passes++;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_root_leaf();
    int lat;
    sendVector('0);
    waitResult(lat);
    checks++; if (lat !== 1) $display("[TB] FAIL root_leaf_latency: got %0d expected 1", lat); else passes++;
    checks++; if (out_class !== 4'd0) $display("[TB] FAIL root_leaf_class: got %0d expected 0", out_class); else passes++;
    checks++; if (out_err !== 1'b0) $display("[TB] FAIL root_leaf_err: got %b expected 0", out_err); else passes++;
    ack();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL root_leaf_drop_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL root_leaf_back_idle: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_two_level();
    int lat;
    logic [7:0]      val   [3] = '{8'h3F, 8'h40, 8'h00};
    logic [7:0]      other [3] = '{8'h00, 8'h00, 8'hFF};
    logic [3:0]      expC  [3] = '{4'd7, 4'd9, 4'd7};
    writeNode(6'd0, mkInt(4'd5, 8'h3F, 6'd1, 6'd2));
    writeNode(6'd1, mkLeaf(4'd7));
    writeNode(6'd2, mkLeaf(4'd9));
    for (int i = 0; i < 3; i++) begin
      sendVector(featWith(5, val[i], other[i]));
      waitResult(lat);
      checks++; if (lat !== 2) $display("[TB] FAIL two_level_latency[%0d]: got %0d expected 2", i, lat); else passes++;
      checks++; if (out_class !== expC[i]) $display("[TB] FAIL two_level_class[%0d]: got %0d expected %0d", i, out_class, expC[i]); else passes++;
      checks++; if (out_err !== 1'b0) $display("[TB] FAIL two_level_err[%0d]: got %b expected 0", i, out_err); else passes++;
      ack();
    end
  endtask

  task automatic test_self_loop();
    int lat;
    writeNode(6'd0, mkInt(4'd0, 8'h00, 6'd0, 6'd0));
    sendVector('0);
    waitResult(lat);
    checks++; if (lat !== 16) $display("[TB] FAIL self_loop_latency: got %0d expected 16", lat); else passes++;
    checks++; if (out_err !== 1'b1) $display("[TB] FAIL self_loop_err: got %b expected 1", out_err); else passes++;
    checks++; if (out_class !== 4'd0) $display("[TB] FAIL self_loop_class: got %0d expected 0", out_class); else passes++;
    ack();
    checks++; if (out_err !== 1'b1) $display("[TB] FAIL self_loop_err_hold: got %b expected 1", out_err); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    writeNode(6'd0, mkInt(4'd5, 8'h3F, 6'd1, 6'd2));
    sendVector(featWith(5, 8'h40, 8'h00));
    waitResult(lat);
    checks++; if (lat !== 2) $display("[TB] FAIL bp_first_latency: got %0d expected 2", lat); else passes++;
    checks++; if (out_err !== 1'b0) $display("[TB] FAIL bp_first_err: got %b expected 0", out_err); else passes++;
    in_feat   = featWith(5, 8'h3F, 8'h00);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b1 || out_class !== 4'd9) $display("[TB] FAIL bp_hold[%0d]: got valid=%b class=%0d expected valid=1 class=9", c, out_valid, out_class); else passes++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); else passes++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    in_feat  = '1;
    waitResult(lat);
    checks++; if (lat !== 2) $display("[TB] FAIL bp_second_latency: got %0d expected 2", lat); else passes++;
    checks++; if (out_class !== 4'd7) $display("[TB] FAIL bp_second_class: got %0d expected 7", out_class); else passes++;
    ack();
  endtask

  task automatic test_cfg_drop();
    int lat;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL cfg_drop_idle: got %b expected 1", in_ready); else passes++;
    in_feat  = featWith(5, 8'h00, 8'h00);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (cfg_busy !== 1'b1) $display("[TB] FAIL cfg_busy_walk: got %b expected 1", cfg_busy); else passes++;
    writeNode(6'd1, mkLeaf(4'd3));
    waitResult(lat);
    checks++; if (lat !== 1) $display("[TB] FAIL cfg_drop_latency: got %0d expected 1", lat); else passes++;
    checks++; if (out_class !== 4'd7) $display("[TB] FAIL cfg_drop_class: got %0d expected 7", out_class); else passes++;
    ack();
    writeNode(6'd1, mkLeaf(4'd3));
    sendVector(featWith(5, 8'h00, 8'h00));
    waitResult(lat);
    checks++; if (lat !== 2) $display("[TB] FAIL cfg_idle_latency: got %0d expected 2", lat); else passes++;
    checks++; if (out_class !== 4'd3) $display("[TB] FAIL cfg_idle_class: got %0d expected 3", out_class); else passes++;
    ack();
  endtask

  task automatic test_reset_midwalk();
    int lat;
    for (int i = 0; i < 5; i++) begin
      writeNode(6'(i), mkInt(4'd0, 8'hFF, 6'(i+1), 6'(i+1)));
    end
    writeNode(6'd5, mkLeaf(4'd5));
    sendVector('0);
    waitResult(lat);
    checks++; if (lat !== 6) $display("[TB] FAIL depth5_latency: got %0d expected 6", lat); else passes++;
    checks++; if (out_class !== 4'd5) $display("[TB] FAIL depth5_class: got %0d expected 5", out_class); else passes++;
    ack();
    sendVector('0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midwalk_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midwalk_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (cfg_busy !== 1'b0) $display("[TB] FAIL midwalk_cfg_busy: got %b expected 0", cfg_busy); else passes++;
    #3;
    rst_n = 1'b1;
    tick();
    sendVector('0);
    waitResult(lat);
    checks++; if (lat !== 1) $display("[TB] FAIL after_reset_latency: got %0d expected 1", lat); else passes++;
    checks++; if (out_class !== 4'd0) $display("[TB] FAIL after_reset_class: got %0d expected 0", out_class); else passes++;
    checks++; if (out_err !== 1'b0) $display("[TB] FAIL after_reset_err: got %b expected 0", out_err); else passes++;
    ack();
  endtask

  // Run every scenario in order, then report.
  initial begin
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    test_reset();
    test_root_leaf();
    test_two_level();
    test_self_loop();
    test_back_to_back();
    test_cfg_drop();
    test_reset_midwalk();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
